// File: rtl/bus_halver_pkg.sv
// bus_halver shared types: FSM state, width constants and the word bundle.
// Optional beat swap selected by BUS_HALVER_SWAP_EN in bus_halver.
package bus_halver_pkg;

    localparam int OUT_W = 8;
    localparam int IN_W  = 2 * OUT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    typedef struct packed {
        logic            hsync;
        logic            vsync;
        logic            den;
        logic [IN_W-1:0] data;
    } word_t;

    localparam int WORD_W = $bits(word_t);

endpackage

// File: rtl/bus_halver_hold.sv
// One-entry holding register for bus_halver with sticky overflow detect.
// A load while full and not unloading in the same cycle drops the new word.
module bus_halver_hold
    import bus_halver_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         in_clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] load_word,
    output logic [W-1:0] word,
    output logic         vld,
    output logic         ovf
);

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            vld  <= 1'b0;
            ovf  <= 1'b0;
        end else if (unload) begin
            // slot frees and refills on the same edge
            vld <= load;
            if (load) word <= load_word;
        end else if (load) begin
            if (vld) begin
                ovf <= 1'b1;
            end else begin
                word <= load_word;
                vld  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_halver.sv
// 16-bit double-pixel to 8-bit pixel serializer with one-word hold slot.
// Define BUS_HALVER_SWAP_EN to emit in_data[15:8] before in_data[7:0].
module bus_halver
    import bus_halver_pkg::*;
#(
    parameter int OUTPUT_WIDTH = OUT_W,
    localparam int INPUT_WIDTH = 2 * OUTPUT_WIDTH
) (
    input  logic                    in_clk,
    input  logic                    rst_n,
    input  logic                    in_stb,
    input  logic                    in_hsync,
    input  logic                    in_vsync,
    input  logic                    in_den,
    input  logic [INPUT_WIDTH-1:0]  in_data,
    output logic                    out_hsync,
    output logic                    out_vsync,
    output logic                    out_den,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    out_busy,
    output logic                    out_ovf
);

`ifdef BUS_HALVER_SWAP_EN
    localparam logic SWAP = 1'b1;
`else
    localparam logic SWAP = 1'b0;
`endif

    state_t state;
    word_t  cur;
    word_t  in_word;
    word_t  pend;
    logic   pend_vld;
    logic   hold_load;
    logic   hold_unload;

    assign in_word = '{
        hsync: in_hsync,
        vsync: in_vsync,
        den:   in_den,
        data:  in_data
    };

    function automatic logic [OUTPUT_WIDTH-1:0] beat(
        input word_t w,
        input logic  second
    );
        logic [OUTPUT_WIDTH-1:0] px;
        if (second ^ SWAP) px = w.data[INPUT_WIDTH-1:OUTPUT_WIDTH];
        else               px = w.data[OUTPUT_WIDTH-1:0];
        return w.den ? px : '0;
    endfunction

    always_comb begin
        hold_load   = 1'b0;
        hold_unload = 1'b0;
        unique case (1'b1)
            state == LOW: begin
                hold_load = in_stb;
            end
            state == HIGH: begin
                hold_unload = pend_vld;
                hold_load   = in_stb && pend_vld;
            end
            default: ;
        endcase
    end

    bus_halver_hold #(
        .W(WORD_W)
    ) u_hold (
        .in_clk    (in_clk),
        .rst_n     (rst_n),
        .load      (hold_load),
        .unload    (hold_unload),
        .load_word (in_word),
        .word      (pend),
        .vld       (pend_vld),
        .ovf       (out_ovf)
    );

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_den   <= 1'b0;
            out_data  <= '0;
            out_busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // syncs are levels: keep the last emitted values
                    out_den  <= 1'b0;
                    out_data <= '0;
                    out_busy <= in_stb;
                    if (in_stb) begin
                        cur   <= in_word;
                        state <= LOW;
                    end
                end
                LOW: begin
                    out_hsync <= cur.hsync;
                    out_vsync <= cur.vsync;
                    out_den   <= cur.den;
                    out_data  <= beat(cur, 1'b0);
                    out_busy  <= 1'b1;
                    state     <= HIGH;
                end
                HIGH: begin
                    out_hsync <= cur.hsync;
                    out_vsync <= cur.vsync;
                    out_den   <= cur.den;
                    out_data  <= beat(cur, 1'b1);
                    out_busy  <= pend_vld || in_stb;
                    if (pend_vld) begin
                        cur   <= pend;
                        state <= LOW;
                    end else if (in_stb) begin
                        cur   <= in_word;
                        state <= LOW;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_halver.sv
// Directed table-driven bench for bus_halver plus a mid-word reset sequence.
// Honours BUS_HALVER_SWAP_EN for the expected beat order.
module tb_bus_halver;

    logic        in_clk;
    logic        rst_n;
    logic        in_stb;
    logic        in_hsync;
    logic        in_vsync;
    logic        in_den;
    logic [15:0] in_data;
    logic        out_hsync;
    logic        out_vsync;
    logic        out_den;
    logic [7:0]  out_data;
    logic        out_busy;
    logic        out_ovf;

    int total;
    int bad;

    bus_halver dut (
        .in_clk    (in_clk),
        .rst_n     (rst_n),
        .in_stb    (in_stb),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .in_den    (in_den),
        .in_data   (in_data),
        .out_hsync (out_hsync),
        .out_vsync (out_vsync),
        .out_den   (out_den),
        .out_data  (out_data),
        .out_busy  (out_busy),
        .out_ovf   (out_ovf)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        logic        stb;
        logic        hs;
        logic        vs;
        logic        den;
        logic [15:0] data;
        logic        e_hs;
        logic        e_vs;
        logic        e_den;
        logic [7:0]  e_data;
        logic        e_busy;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] b1(input logic [15:0] w);
`ifdef BUS_HALVER_SWAP_EN
        return w[15:8];
`else
        return w[7:0];
`endif
    endfunction

    function automatic logic [7:0] b2(input logic [15:0] w);
`ifdef BUS_HALVER_SWAP_EN
        return w[7:0];
`else
        return w[15:8];
`endif
    endfunction

    function automatic vec_t v(
        input logic stb, input logic hs, input logic vs,
        input logic den, input logic [15:0] data,
        input logic e_hs, input logic e_vs, input logic e_den,
        input logic [7:0] e_data, input logic e_busy, input logic e_ovf
    );
        vec_t r;
        r.stb = stb; r.hs = hs; r.vs = vs; r.den = den; r.data = data;
        r.e_hs = e_hs; r.e_vs = e_vs; r.e_den = e_den;
        r.e_data = e_data; r.e_busy = e_busy; r.e_ovf = e_ovf;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic hs,
                              input logic vs, input logic den,
                              input logic [7:0] data, input logic busy,
                              input logic ovf);
        check({tag, ".hsync"}, 32'(out_hsync), 32'(hs));
        check({tag, ".vsync"}, 32'(out_vsync), 32'(vs));
        check({tag, ".den"},   32'(out_den),   32'(den));
        check({tag, ".data"},  32'(out_data),  32'(data));
        check({tag, ".busy"},  32'(out_busy),  32'(busy));
        check({tag, ".ovf"},   32'(out_ovf),   32'(ovf));
    endtask

    task automatic drive(input logic stb, input logic hs, input logic vs,
                         input logic den, input logic [15:0] data);
        in_stb   = stb;
        in_hsync = hs;
        in_vsync = vs;
        in_den   = den;
        in_data  = data;
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF);

        // single word
        tbl.push_back(v(1,0,0,1,16'hA108, 0,0,0,8'h00,1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b1(16'hA108),1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b2(16'hA108),0,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,0,8'h00,0,0));
        // strobe every 2nd cycle, gapless
        tbl.push_back(v(1,0,0,1,16'h5303, 0,0,0,8'h00,1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b1(16'h5303),1,0));
        tbl.push_back(v(1,0,0,1,16'h2310, 0,0,1,b2(16'h5303),1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b1(16'h2310),1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b2(16'h2310),0,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,0,8'h00,0,0));
        // blanking word, syncs hold in idle
        tbl.push_back(v(1,1,1,0,16'h8123, 0,0,0,8'h00,1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 1,1,0,8'h00,1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 1,1,0,8'h00,0,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 1,1,0,8'h00,0,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 1,1,0,8'h00,0,0));
        // three back-to-back words: hold slot refilled as it unloads
        tbl.push_back(v(1,0,0,1,16'h1122, 1,1,0,8'h00,1,0));
        tbl.push_back(v(1,0,0,1,16'h3344, 0,0,1,b1(16'h1122),1,0));
        tbl.push_back(v(1,0,0,1,16'h5566, 0,0,1,b2(16'h1122),1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b1(16'h3344),1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b2(16'h3344),1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b1(16'h5566),1,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b2(16'h5566),0,0));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,0,8'h00,0,0));
        // four back-to-back: the fourth finds the slot full and is dropped
        tbl.push_back(v(1,0,0,1,16'h4142, 0,0,0,8'h00,1,0));
        tbl.push_back(v(1,0,0,1,16'h5152, 0,0,1,b1(16'h4142),1,0));
        tbl.push_back(v(1,0,0,1,16'h6162, 0,0,1,b2(16'h4142),1,0));
        tbl.push_back(v(1,0,0,1,16'h7172, 0,0,1,b1(16'h5152),1,1));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b2(16'h5152),1,1));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b1(16'h6162),1,1));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,1,b2(16'h6162),0,1));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,0,8'h00,0,1));
        tbl.push_back(v(0,0,0,0,16'h0000, 0,0,0,8'h00,0,1));

        repeat (3) tick();
        check_outs("reset", 0, 0, 0, 8'h00, 0, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        check_outs("post_reset", 0, 0, 0, 8'h00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stb, tbl[i].hs, tbl[i].vs, tbl[i].den,
                  tbl[i].data);
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].e_hs, tbl[i].e_vs,
                       tbl[i].e_den, tbl[i].e_data, tbl[i].e_busy,
                       tbl[i].e_ovf);
        end

        // reset while second beat pending and hold slot full
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h5678);
        tick();
        check_outs("mid_beat", 1, 1, 1, b1(16'h1234), 1, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0, 8'h00, 0, 0);
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_outs($sformatf("no_stale%0d", i), 0, 0, 0, 8'h00, 0, 0);
        end

        // normal operation resumes after reset
        drive(1'b1, 0, 0, 1, 16'hC3D4);
        tick();
        drive(1'b0, 0, 0, 0, 16'h0000);
        check_outs("resume0", 0, 0, 0, 8'h00, 1, 0);
        tick();
        check_outs("resume1", 0, 0, 1, b1(16'hC3D4), 1, 0);
        tick();
        check_outs("resume2", 0, 0, 1, b2(16'hC3D4), 0, 0);
        tick();
        check_outs("resume3", 0, 0, 0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
